bit_packer: RTL and testbench

BIT_PACKER -- requirements
Module: bit_packer

---
 rtl/bit_packer.sv | 118 +++++++++++
 tb/tb_bit_packer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bit_packer.sv
// Serial-to-parallel packer: collects WIDTH bits into a word, holds it with popcount for a valid/ready consumer.
// Latency: word_valid asserts one edge after the last bit; a word completing while one is held and not taken sets sticky overflow.
// Optional parity output under BIT_PACKER_PARITY_EN.
module bit_packer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic [WIDTH-1:0]           word_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [$clog2(WIDTH+1)-1:0] ones_count,
    output logic                       overflow,
    output logic                       busy
`ifdef BIT_PACKER_PARITY_EN
   ,output logic                       parity
`endif
);

    localparam int OC_W  = $clog2(WIDTH + 1);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   word_q;
    logic [OC_W-1:0]    ones_q;
    logic               ovf_q;
    logic               complete;
    logic               handshake;
`ifdef BIT_PACKER_PARITY_EN
    logic               parity_q;
`endif

    function automatic logic [OC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [OC_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + OC_W'(v[i]);
        end
        return n;
    endfunction

    // sr_d already includes the incoming bit, so on completion it is the finished word.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (bit_valid) begin
            if (MSB_FIRST) begin
                sr_d = {sr_q[WIDTH-2:0], bit_in};
            end else begin
                sr_d = {bit_in, sr_q[WIDTH-1:1]};
            end
            cnt_d = (cnt_q == CNT_W'(WIDTH - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign complete  = bit_valid && (cnt_q == CNT_W'(WIDTH - 1));
    assign handshake = (state_q == FULL) && word_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            sr_q     <= '0;
            cnt_q    <= '0;
            word_q   <= '0;
            ones_q   <= '0;
            ovf_q    <= 1'b0;
`ifdef BIT_PACKER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            case (state_q)
                EMPTY: begin
                    if (complete) begin
                        word_q   <= sr_d;
                        ones_q   <= popcount(sr_d);
`ifdef BIT_PACKER_PARITY_EN
                        parity_q <= ^sr_d;
`endif
                        state_q  <= FULL;
                    end
                end
                FULL: begin
                    if (complete && handshake) begin
                        word_q   <= sr_d;
                        ones_q   <= popcount(sr_d);
`ifdef BIT_PACKER_PARITY_EN
                        parity_q <= ^sr_d;
`endif
                    end else if (complete) begin
                        ovf_q    <= 1'b1;
                    end else if (handshake) begin
                        state_q  <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign word_out   = word_q;
    assign ones_count = ones_q;
    assign word_valid = (state_q == FULL);
    assign overflow   = ovf_q;
    assign busy       = (cnt_q != '0);
`ifdef BIT_PACKER_PARITY_EN
    assign parity     = parity_q;
`endif

endmodule

// File: tb/tb_bit_packer.sv
// Bench for bit_packer: MSB-first and LSB-first instances share one bit stream and are checked against a queue-based model.
module tb_bit_packer;

    localparam int W   = 8;
    localparam int OCW = $clog2(W + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           bit_in = 1'b0;
    logic           bit_valid = 1'b0;
    logic           word_ready = 1'b0;
    logic [W-1:0]   wo_m, wo_l;
    logic [OCW-1:0] oc_m, oc_l;
    logic           wv_m, wv_l, ov_m, ov_l, busy_m, busy_l;
`ifdef BIT_PACKER_PARITY_EN
    logic           par_m, par_l;
`endif

    always #5 clk = ~clk;

    bit_packer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .word_out(wo_m), .word_valid(wv_m), .word_ready(word_ready),
        .ones_count(oc_m), .overflow(ov_m), .busy(busy_m)
`ifdef BIT_PACKER_PARITY_EN
       ,.parity(par_m)
`endif
    );

    bit_packer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .word_out(wo_l), .word_valid(wv_l), .word_ready(word_ready),
        .ones_count(oc_l), .overflow(ov_l), .busy(busy_l)
`ifdef BIT_PACKER_PARITY_EN
       ,.parity(par_l)
`endif
    );

    // Reference model: bits of the partial word in arrival order, plus the held word per bit order.
    bit           q_bits[$];
    logic [W-1:0] e_wm = '0, e_wl = '0;
    bit           e_valid = 1'b0, e_ovf = 1'b0;
    int           n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step(input logic r, input logic bv, input logic b, input logic rdy);
        bit           hs, comp;
        logic [W-1:0] pm, pl;
        rst = r; bit_valid = bv; bit_in = b; word_ready = rdy;
        @(posedge clk);
        #1;
        comp = 1'b0; pm = '0; pl = '0;
        if (r) begin
            q_bits.delete();
            e_valid = 1'b0; e_ovf = 1'b0; e_wm = '0; e_wl = '0;
        end else begin
            hs = e_valid && rdy;
            if (bv) begin
                q_bits.push_back(b);
                if (q_bits.size() == W) begin
                    comp = 1'b1;
                    for (int i = 0; i < W; i++) begin
                        pm = pm | (W'(q_bits[i]) << (W - 1 - i));
                        pl = pl | (W'(q_bits[i]) << i);
                    end
                    q_bits.delete();
                end
            end
            if (comp) begin
                if (!e_valid || hs) begin
                    e_wm = pm; e_wl = pl; e_valid = 1'b1;
                end else begin
                    e_ovf = 1'b1;
                end
            end else if (hs) begin
                e_valid = 1'b0;
            end
        end
        check("word_msb",  wo_m,   e_wm);
        check("word_lsb",  wo_l,   e_wl);
        check("ones_msb",  oc_m,   $countones(e_wm));
        check("ones_lsb",  oc_l,   $countones(e_wl));
        check("valid_msb", wv_m,   e_valid);
        check("valid_lsb", wv_l,   e_valid);
        check("ovf_msb",   ov_m,   e_ovf);
        check("ovf_lsb",   ov_l,   e_ovf);
        check("busy_msb",  busy_m, q_bits.size() != 0);
        check("busy_lsb",  busy_l, q_bits.size() != 0);
`ifdef BIT_PACKER_PARITY_EN
        check("par_msb",   par_m,  ^e_wm);
        check("par_lsb",   par_l,  ^e_wl);
`endif
    endtask

    // Feeds w[7] first; last_rdy is the ready level on the edge carrying the final bit.
    task automatic feed_word(input logic [7:0] w, input logic rdy, input logic last_rdy, input bit gaps);
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 1'b1, w[i], (i == 0) ? last_rdy : rdy);
            if (gaps && i != 0) step(1'b0, 1'b0, 1'($urandom), rdy);
        end
    endtask

    initial begin
        int thr;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_valid", wv_m, 16'd0);
        check("rst_word",  wo_m, 16'd0);

        feed_word(8'hB2, 1'b1, 1'b1, 1'b0);
        check("r25_word_msb", wo_m, 16'hB2);
        check("r25_ones",     oc_m, 16'd4);
        check("r26_word_lsb", wo_l, 16'h4D);
        check("r25_valid",    wv_m, 16'd1);
        check("r25_ovf",      ov_m, 16'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("r25_valid_one_cycle", wv_m, 16'd0);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        feed_word(8'hFF, 1'b0, 1'b0, 1'b0);
        feed_word(8'h01, 1'b0, 1'b0, 1'b0);
        check("r27_word", wo_m, 16'hFF);
        check("r27_ovf",  ov_m, 16'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("r27_ovf_sticky", ov_m, 16'd1);
        check("r27_valid_drop", wv_m, 16'd0);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        feed_word(8'h0F, 1'b0, 1'b0, 1'b0);
        feed_word(8'hF0, 1'b0, 1'b1, 1'b0);
        check("r28_valid", wv_m, 16'd1);
        check("r28_word",  wo_m, 16'hF0);
        check("r28_ovf",   ov_m, 16'd0);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'($urandom), 1'b1);
        check("r29_busy_before", busy_m, 16'd1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("r29_busy_after", busy_m, 16'd0);
        feed_word(8'hA5, 1'b1, 1'b1, 1'b0);
        check("r29_word", wo_m, 16'hA5);
        check("r29_ones", oc_m, 16'd4);
`ifdef BIT_PACKER_PARITY_EN
        check("r29_parity", par_m, 16'd0);
`endif

        step(1'b1, 1'b0, 1'b0, 1'b0);
        feed_word(8'h3C, 1'b1, 1'b1, 1'b1);
        check("r30_word", wo_m, 16'h3C);
        check("r30_ones", oc_m, 16'd4);

        for (int n = 0; n < 3000; n++) begin
            thr = (n / 500) % 3 == 0 ? 10 : ((n / 500) % 3 == 1 ? 50 : 90);
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 2) != 0,
                 1'($urandom),
                 $urandom_range(0, 99) < thr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
